// File: rtl/tm1638_if.sv
// TM1638 3-wire pin bus (STB / CLK / DIO split into drive value and enable).
// The controller drives strobe, clock and DIO value/enable; the board (or a
// bus model) returns the DIO pad level on dio_in.
//   sio_stb  strobe, active-low
//   sio_clk  serial clock, idles high
//   dio_out  DIO value while driven
//   dio_oe   DIO drive enable, 0 releases the line for key reads
//   dio_in   DIO pad level, asynchronous to clk
interface tm1638_if;
   logic sio_stb;
   logic sio_clk;
   logic dio_out;
   logic dio_oe;
   logic dio_in;

   modport master (output sio_stb, output sio_clk, output dio_out, output dio_oe, input dio_in);
   modport slave  (input sio_stb, input sio_clk, input dio_out, input dio_oe, output dio_in);
endinterface

// File: rtl/tm1638_controller.sv
// Frame sequencer for a TM1638 display/key board. Once per refresh period it
// snapshots the segment patterns and LED vector, writes them to the chip with
// auto-increment addressing, sets the brightness, then reads the 4 key bytes.
//   clk, rst  system clock, asynchronous active-high reset
//   hex       segment pattern per digit (hgfedcba), hex[k] -> digit k
//   led       discrete LEDs, led[k] -> LED k
//   keys      last key-scan result, 1 = pressed
//   keys_vld  one-cycle pulse when keys is refreshed
//   busy      high from frame start through the final DONE cycle
//   bus       TM1638 pin bus (master side)
module tm1638_controller #(
   parameter int w_digit        = 8,
   parameter int w_seg          = 8,
   parameter int CLK_DIV        = 16,
   parameter int REFRESH_CYCLES = 500_000,
   parameter int BRIGHTNESS     = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [w_digit-1:0][w_seg-1:0] hex,
   input  logic [7:0]                    led,
   output logic [7:0]                    keys,
   output logic                          keys_vld,
   output logic                          busy,
   tm1638_if.master                      bus
);

   localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int DW = $clog2(2 * CLK_DIV);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LAST = DW'(2 * CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, T_MODE, GAP, T_DATA, T_DISP, T_READ, DONE} state_t;
   typedef enum logic [1:0] {PH_SETUP, PH_LOW, PH_HIGH, PH_TURN} phase_t;

   state_t          state;
   state_t          gap_next;
   phase_t          phase;
   logic [RW-1:0]   ref_cnt;
   logic [DW-1:0]   div_cnt;
   logic [2:0]      bit_idx;
   logic [4:0]      byte_idx;
   logic [4:0]      rd_cnt;
   logic            rd_mode;
   logic [7:0]      sh;
   logic [30:0]     rd_data;
   logic [7:0][7:0] hex_sh;
   logic [7:0]      led_sh;
   logic            pending;
   logic            dio_s1;
   logic            dio_s2;
   logic            stb_q;
   logic            sclk_q;
   logic            dout_q;
   logic            oe_q;

   logic            wrap;
   logic            start;
   logic [7:0][7:0] hex_pad;
   logic [3:0]      data_idx;
   logic [7:0]      next_byte;
   logic [4:0]      tx_bytes;
   logic [31:0]     rd_next;
   logic [7:0]      key_map;

   assign bus.sio_stb = stb_q;
   assign bus.sio_clk = sclk_q;
   assign bus.dio_out = dout_q;
   assign bus.dio_oe  = oe_q;

   assign wrap  = (ref_cnt == REF_LAST);
   assign start = ((state == IDLE) && wrap) || ((state == DONE) && (pending || wrap));

   // Free-running refresh timer; its wrap is the frame request, whether or
   // not a frame is currently running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt <= '0;
      end else if (wrap) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   // The DIO pad is asynchronous to clk, so it goes through two flops before
   // the key shift register ever looks at it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dio_s1 <= 1'b1;
         dio_s2 <= 1'b1;
      end else begin
         dio_s1 <= bus.dio_in;
         dio_s2 <= dio_s1;
      end
   end

   // Digits beyond w_digit are padded with blank patterns so the data
   // transaction always writes all 8 grid addresses.
   always_comb begin
      hex_pad = '0;
      for (int k = 0; k < w_digit; k++) begin
         hex_pad[k] = hex[k];
      end
   end

   // Byte about to be shifted out: byte_idx names the next byte of the
   // current transaction. Data bytes alternate digit pattern / LED bit.
   always_comb begin
      data_idx  = 4'(byte_idx - 5'd1);
      next_byte = 8'h00;
      tx_bytes  = (state == T_DATA) ? 5'd17 : 5'd1;
      case (state)
         T_MODE: next_byte = 8'h40;
         T_DATA: begin
            if (byte_idx == 5'd0) begin
               next_byte = 8'hC0;
            end else if (!data_idx[0]) begin
               next_byte = hex_sh[data_idx[3:1]];
            end else begin
               next_byte = {7'b0, led_sh[data_idx[3:1]]};
            end
         end
         T_DISP:  next_byte = {5'b10001, 3'(BRIGHTNESS)};
         T_READ:  next_byte = 8'h42;
         default: next_byte = 8'h00;
      endcase
   end

   // Read bits arrive LSB first; rd_next includes the bit being sampled now
   // so the key map can be built on the same edge that ends the last bit.
   always_comb begin
      rd_next = {dio_s2, rd_data};
      key_map = '0;
      for (int b = 0; b < 4; b++) begin
         key_map[b]     = rd_next[8*b];
         key_map[b + 4] = rd_next[8*b + 4];
      end
   end

   // Frame sequencer. Each transaction is: strobe low for CLK_DIV cycles,
   // then per bit a low phase (new data bit) and a high phase (chip latches,
   // or we sample a read bit in its last cycle). The read transaction adds a
   // turnaround with DIO released before the 32 read bits. A refresh request
   // that arrives mid-frame is remembered and served straight after DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gap_next <= T_DATA;
         phase    <= PH_SETUP;
         div_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         rd_cnt   <= '0;
         rd_mode  <= 1'b0;
         sh       <= '0;
         rd_data  <= '0;
         hex_sh   <= '0;
         led_sh   <= '0;
         pending  <= 1'b0;
         stb_q    <= 1'b1;
         sclk_q   <= 1'b1;
         dout_q   <= 1'b1;
         oe_q     <= 1'b1;
         keys     <= '0;
         keys_vld <= 1'b0;
         busy     <= 1'b0;
      end else begin
         keys_vld <= 1'b0;
         if (start) begin
            pending <= 1'b0;
         end else if (wrap && (state != IDLE)) begin
            pending <= 1'b1;
         end

         if (start) begin
            hex_sh   <= hex_pad;
            led_sh   <= led;
            busy     <= 1'b1;
            state    <= T_MODE;
            stb_q    <= 1'b0;
            phase    <= PH_SETUP;
            div_cnt  <= '0;
            byte_idx <= '0;
            rd_mode  <= 1'b0;
         end else begin
            case (state)
               T_MODE, T_DATA, T_DISP, T_READ: begin
                  div_cnt <= div_cnt + 1'b1;
                  case (phase)
                     PH_SETUP: begin
                        if (div_cnt == DIV_LAST) begin
                           div_cnt  <= '0;
                           phase    <= PH_LOW;
                           sclk_q   <= 1'b0;
                           sh       <= next_byte;
                           dout_q   <= next_byte[0];
                           bit_idx  <= '0;
                           byte_idx <= byte_idx + 5'd1;
                        end
                     end
                     PH_LOW: begin
                        if (div_cnt == DIV_LAST) begin
                           div_cnt <= '0;
                           phase   <= PH_HIGH;
                           sclk_q  <= 1'b1;
                        end
                     end
                     PH_HIGH: begin
                        if (div_cnt == DIV_LAST) begin
                           div_cnt <= '0;
                           if (rd_mode) begin
                              rd_data <= rd_next[31:1];
                              if (rd_cnt == 5'd31) begin
                                 state    <= DONE;
                                 stb_q    <= 1'b1;
                                 oe_q     <= 1'b1;
                                 keys     <= key_map;
                                 keys_vld <= 1'b1;
                              end else begin
                                 rd_cnt <= rd_cnt + 5'd1;
                                 phase  <= PH_LOW;
                                 sclk_q <= 1'b0;
                              end
                           end else if (bit_idx != 3'd7) begin
                              bit_idx <= bit_idx + 3'd1;
                              dout_q  <= sh[1];
                              sh      <= {1'b0, sh[7:1]};
                              phase   <= PH_LOW;
                              sclk_q  <= 1'b0;
                           end else if (byte_idx != tx_bytes) begin
                              sh       <= next_byte;
                              dout_q   <= next_byte[0];
                              bit_idx  <= '0;
                              byte_idx <= byte_idx + 5'd1;
                              phase    <= PH_LOW;
                              sclk_q   <= 1'b0;
                           end else if (state == T_READ) begin
                              dout_q <= 1'b1;
                              oe_q   <= 1'b0;
                              phase  <= PH_TURN;
                           end else begin
                              dout_q   <= 1'b1;
                              stb_q    <= 1'b1;
                              state    <= GAP;
                              gap_next <= (state == T_MODE) ? T_DATA :
                                          (state == T_DATA) ? T_DISP : T_READ;
                           end
                        end
                     end
                     PH_TURN: begin
                        if (div_cnt == DIV_LAST) begin
                           div_cnt <= '0;
                           rd_mode <= 1'b1;
                           rd_cnt  <= '0;
                           phase   <= PH_LOW;
                           sclk_q  <= 1'b0;
                        end
                     end
                     default: phase <= PH_SETUP;
                  endcase
               end
               GAP: begin
                  div_cnt <= div_cnt + 1'b1;
                  if (div_cnt == GAP_LAST) begin
                     state    <= gap_next;
                     stb_q    <= 1'b0;
                     phase    <= PH_SETUP;
                     div_cnt  <= '0;
                     byte_idx <= '0;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
